// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is computed in full at the accepting edge into shadow registers
// and is only committed to HI/LO when the busy period has elapsed, so HI/LO
// never show a partial or early update.
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic             state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic [2*WIDTH-1:0] a_sx, b_sx, a_zx, b_zx;
    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, q_mag, r_mag, q_s, r_s;
    logic [WIDTH-1:0]   q_u, r_u;

    // Arithmetic datapath: products and quotients of the current operands.
    always_comb begin
        a_sx   = {{WIDTH{a[WIDTH-1]}}, a};
        b_sx   = {{WIDTH{b[WIDTH-1]}}, b};
        a_zx   = {{WIDTH{1'b0}}, a};
        b_zx   = {{WIDTH{1'b0}}, b};
        // Low 2*WIDTH bits of the extended product are the exact signed product.
        prod_s = a_sx * b_sx;
        prod_u = a_zx * b_zx;

        a_neg  = a[WIDTH-1];
        b_neg  = b[WIDTH-1];
        // Most-negative dividend negates to itself, which is its correct magnitude
        // when read unsigned; MIN / -1 then wraps back to MIN with remainder 0.
        a_mag  = a_neg ? (WIDTH'(0) - a) : a;
        b_mag  = b_neg ? (WIDTH'(0) - b) : b;
        q_mag  = '0;
        r_mag  = '0;
        q_u    = '0;
        r_u    = '0;
        if (b != '0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
            q_u   = a / b;
            r_u   = a % b;
        end
        q_s = (a_neg ^ b_neg) ? (WIDTH'(0) - q_mag) : q_mag;
        r_s = a_neg ? (WIDTH'(0) - r_mag) : r_mag;
    end

    // Next-state logic: accept in IDLE, count down in RUN, commit on the last count.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT: begin
                            res_hi_d = prod_s[2*WIDTH-1:WIDTH];
                            res_lo_d = prod_s[WIDTH-1:0];
                            cnt_d    = MULT_LOAD;
                            state_d  = ST_RUN;
                        end
                        OP_MULTU: begin
                            res_hi_d = prod_u[2*WIDTH-1:WIDTH];
                            res_lo_d = prod_u[WIDTH-1:0];
                            cnt_d    = MULT_LOAD;
                            state_d  = ST_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            // HI/LO cannot change while busy, so a zero divisor
                            // simply shadows the current values and commits them back.
                            if (b == '0) begin
                                res_hi_d = hi_q;
                                res_lo_d = lo_q;
                            end else if (op == OP_DIV) begin
                                res_hi_d = r_s;
                                res_lo_d = q_s;
                            end else begin
                                res_hi_d = r_u;
                                res_lo_d = q_u;
                            end
                            cnt_d   = DIV_LOAD;
                            state_d = ST_RUN;
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    hi_d    = res_hi_q;
                    lo_d    = res_lo_q;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: a cycle-level reference model predicts
// HI/LO/busy/done from the architectural rules, a compare process checks the
// DUT against it every cycle, and directed cases pin known values.
module tb_md_unit;

    localparam int W  = 32;
    localparam int NM = 5;
    localparam int ND = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    md_unit #(
        .WIDTH      (W),
        .MULT_CYCLES(NM),
        .DIV_CYCLES (ND)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .op   (op),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .hi   (hi),
        .lo   (lo)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    bit cmp_en  = 1'b0;

    task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", nm, got, exp, $time);
    endtask

    // Reference model: an accepted op completes a fixed number of edges later.
    logic [W-1:0] m_hi = '0, m_lo = '0, p_hi, p_lo;
    bit           m_pend = 1'b0, m_done = 1'b0;
    longint       cyc = 0, m_fin = 0;

    always @(posedge clk) begin
        longint       sa, sb, sq, sr;
        logic [63:0]  pu;
        cyc++;
        if (reset) begin
            m_hi = '0; m_lo = '0; m_pend = 1'b0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_pend) begin
                if (cyc == m_fin) begin
                    m_hi = p_hi; m_lo = p_lo; m_pend = 1'b0; m_done = 1'b1;
                end
            end else if (start) begin
                sa = $signed(a);
                sb = $signed(b);
                case (op)
                    3'd0: begin
                        sq = sa * sb;
                        p_hi = sq[63:32]; p_lo = sq[31:0];
                        m_pend = 1'b1; m_fin = cyc + NM;
                    end
                    3'd1: begin
                        pu = {32'd0, a} * {32'd0, b};
                        p_hi = pu[63:32]; p_lo = pu[31:0];
                        m_pend = 1'b1; m_fin = cyc + NM;
                    end
                    3'd2: begin
                        if (b == 0) begin p_hi = m_hi; p_lo = m_lo; end
                        else begin
                            sq = sa / sb; sr = sa % sb;
                            p_hi = sr[31:0]; p_lo = sq[31:0];
                        end
                        m_pend = 1'b1; m_fin = cyc + ND;
                    end
                    3'd3: begin
                        if (b == 0) begin p_hi = m_hi; p_lo = m_lo; end
                        else begin p_hi = a % b; p_lo = a / b; end
                        m_pend = 1'b1; m_fin = cyc + ND;
                    end
                    3'd4: m_hi = a;
                    3'd5: m_lo = a;
                    default: ;
                endcase
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_hi", hi, m_hi);
            chk("cyc_lo", lo, m_lo);
            chk("cyc_busy", {31'd0, busy}, {31'd0, m_pend});
            chk("cyc_done", {31'd0, done}, {31'd0, m_done});
        end
    end

    // Issue one op and check busy length plus final HI/LO against literals.
    task automatic run_op(input string nm, input logic [2:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input int n,
                          input logic [W-1:0] eh, input logic [W-1:0] el);
        @(negedge clk); start = 1'b1; op = o; a = x; b = y;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk({nm, "_busy"}, {31'd0, busy}, 32'd1);
            @(negedge clk);
        end
        chk({nm, "_end_busy"}, {31'd0, busy}, 32'd0);
        chk({nm, "_done"}, {31'd0, done}, 32'd1);
        chk({nm, "_hi"}, hi, eh);
        chk({nm, "_lo"}, lo, el);
        chk({nm, "_model_hi"}, m_hi, eh);
        chk({nm, "_model_lo"}, m_lo, el);
        @(negedge clk);
        chk({nm, "_done_clr"}, {31'd0, done}, 32'd0);
    endtask

    task automatic mt(input logic hi_sel, input logic [W-1:0] x);
        @(negedge clk); start = 1'b1; op = hi_sel ? 3'd4 : 3'd5; a = x; b = '0;
        @(negedge clk); start = 1'b0;
        if (hi_sel) chk("mthi", hi, x);
        else        chk("mtlo", lo, x);
        chk("mt_busy", {31'd0, busy}, 32'd0);
    endtask

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        cmp_en = 1'b1;
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);

        run_op("mult", 3'd0, 32'hFFFF_FFFD, 32'd5, NM, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, NM, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, ND, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, ND, 32'h0, 32'h8000_0000);
        mt(1'b1, 32'h11);
        mt(1'b0, 32'h22);
        run_op("divu_by0", 3'd3, 32'd7, 32'd0, ND, 32'h11, 32'h22);
        run_op("divu", 3'd3, 32'd100, 32'd7, ND, 32'd2, 32'd14);

        // MTLO while busy must be ignored.
        @(negedge clk); start = 1'b1; op = 3'd0; a = 32'd6; b = 32'd7;
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1; op = 3'd5; a = 32'h55;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_mtlo_done", {31'd0, done}, 32'd1);
        chk("busy_mtlo_lo", lo, 32'h2A);
        chk("busy_mtlo_hi", hi, 32'h0);

        // Reset in the third busy cycle cancels the operation.
        @(negedge clk); start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("midrst_hi", hi, 32'h0);
        chk("midrst_lo", lo, 32'h0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        repeat (8) @(negedge clk);
        chk("midrst_late_lo", lo, 32'h0);
        chk("midrst_late_hi", hi, 32'h0);
        mt(1'b1, 32'hABCD);

        // Randomized traffic, including starts while busy and reserved ops.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 99) == 0);
            start = ($urandom_range(0, 2) == 0);
            op    = 3'($urandom_range(0, 7));
            a     = rnd_val();
            b     = rnd_val();
        end
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        repeat (ND + 4) @(negedge clk);
        chk("final_idle", {31'd0, busy}, 32'd0);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO registers for the 5-stage pipeline; sits in the E stage beside the ALU.
- Executes MULT/MULTU/DIV/DIVU with configurable latency and services MTHI/MTLO writes.
- Raises busy so the hazard unit can stall dependent MFHI/MFLO/MD instructions in D.
- Successor to the fixed single-ALU E stage: adds width and latency parameters, a multi-cycle state machine and architectural HI/LO state.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits (≥2).
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (≥1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (≥1).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- start  input  1  request valid this cycle; op/a/b sampled at the edge.
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved.
- a  input  WIDTH  rs operand (forwarded value); dividend / multiplicand / MTHI-MTLO data.
- b  input  WIDTH  rt operand; divisor / multiplier.
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse in the cycle HI/LO first show a new mult/div result.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: hi=0, lo=0, busy=0, done=0, counter=0, state IDLE.
- State machine: two states, IDLE and RUN.
- IDLE, start=1, op ∈ {MULT, MULTU, DIV, DIVU}:
  - At that edge, compute the full result into shadow registers res_hi/res_lo.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
  - busy=1 from the next cycle.
- RUN: counter decrements each edge.
  - At the edge where counter goes 1→0: hi/lo ← shadow, busy→0, done→1 for one cycle, state→IDLE.
  - busy is high for exactly N cycles after the accepting edge; new hi/lo are visible in cycle N+1.
- During RUN, hi/lo hold their old values; no early or partial update.
- IDLE, start=1, op=MTHI: hi←a at that edge. op=MTLO: lo←a. busy stays 0, done stays 0.
- start while busy=1: ignored for every op, including MTHI/MTLO. The hazard unit guarantees this never happens; the unit must still not corrupt state.
- Reserved op with start=1: ignored, no state change.
- Start is never accepted in the same cycle busy falls: busy is registered, and acceptance requires busy=0 at the sampling edge.
- MULT: signed 2·WIDTH product; hi=upper WIDTH bits, lo=lower.
- MULTU: the same product, unsigned.
- DIV: signed. lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - Overflow case (most-negative / -1): lo=most-negative, hi=0.
- DIVU: unsigned quotient in lo, remainder in hi.
- Divisor 0 (DIV or DIVU): full DIV_CYCLES busy period still runs; hi/lo unchanged at completion; done still pulses.
- reset asserted mid-RUN: operation is cancelled at that edge; all outputs return to reset values. No deferred write after reset deasserts.
- Counter width is $clog2(max(MULT_CYCLES, DIV_CYCLES)+1).

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5 → busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1, done pulses once.
- MULTU a=0xFFFFFFFF, b=2 → after 5 cycles hi=0x00000001, lo=0xFFFFFFFE. Reading hi/lo during busy returns the prior values.
- DIV a=0xFFFFFFF9 (-7), b=2 → after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=7, b=0 with hi=0x11, lo=0x22 preloaded via MTHI/MTLO → busy 10 cycles; hi=0x11, lo=0x22, done pulses.
- MULT started, then start=1 op=MTLO a=0x55 at busy cycle 2 → MTLO ignored; final lo equals the product.
- MULT started, reset at busy cycle 3 → next cycle hi=lo=0, busy=0. No update occurs after 5 cycles; then MTHI a=0xABCD → hi=0xABCD next cycle, busy never asserted.
